// File: rtl/alu_bist_pkg.sv
// Shared types, constants and LFSR/MISR step functions for the ALU BIST controller.
package alu_bist_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2,
    StCheck = 2'd3
  } state_e;

  localparam logic [31:0] LfsrMask    = 32'h0040_0007;
  localparam logic [15:0] MisrMask    = 16'h1021;
  localparam logic [15:0] MisrInit    = 16'hFFFF;
  localparam logic [31:0] DefaultSeed = 32'hACE1_0001;

  function automatic logic [31:0] lfsr_next(input logic [31:0] l);
    return {l[30:0], 1'b0} ^ (l[31] ? LfsrMask : 32'h0);
  endfunction

  function automatic logic [15:0] misr_next(input logic [15:0] m, input logic [15:0] d);
    return {m[14:0], 1'b0} ^ (m[15] ? MisrMask : 16'h0) ^ d;
  endfunction

endpackage

// File: rtl/alu_bist_if.sv
// Bus between the BIST controller and the ALU under test.
interface alu_bist_if;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic        alu_s0;
  logic        alu_s1;
  logic [15:0] alu_out;

  modport master (output alu_a, output alu_b, output alu_s0, output alu_s1, input alu_out);
  modport slave  (input alu_a, input alu_b, input alu_s0, input alu_s1, output alu_out);
endinterface

// File: rtl/alu_bist_misr.sv
// 16-bit multiple-input signature register; clear has priority over capture.
module alu_bist_misr
  import alu_bist_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic [15:0] data_i,
  output logic [15:0] sig_o
);

  logic [15:0] sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (clr_i) begin
      sig_d = MisrInit;
    end else if (en_i) begin
      sig_d = misr_next(sig_q, data_i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_q <= MisrInit;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig_o = sig_q;

endmodule

// File: rtl/alu_bist_ctrl.sv
// ALU BIST controller: LFSR operand generator, op sequencer and MISR compaction of results.
module alu_bist_ctrl
  import alu_bist_pkg::*;
#(
  parameter int unsigned N_PATTERNS = 64,
  parameter logic [31:0] SEED       = DefaultSeed,
  parameter logic [15:0] GOLDEN_SIG = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              abort_i,
  alu_bist_if.master        alu_io,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic [15:0]       sig_o
);

  localparam int unsigned      CntW    = 12;
  localparam logic [CntW-1:0] LastVec = CntW'(4 * N_PATTERNS - 1);

  state_e          state_q, state_d;
  logic [31:0]     lfsr_q, lfsr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [15:0]     a_q, a_d, b_q, b_d;
  logic [1:0]      sel_q, sel_d;
  logic            busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic            misr_clr, misr_en;
  logic [15:0]     sig;

  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    sel_d    = sel_q;
    busy_d   = busy_q;
    pass_d   = pass_q;
    done_d   = 1'b0;
    misr_clr = 1'b0;
    misr_en  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          lfsr_d   = SEED;
          cnt_d    = '0;
          busy_d   = 1'b1;
          pass_d   = 1'b0;
          misr_clr = 1'b1;
          state_d  = StRun;
        end
      end
      StRun: begin
        a_d   = lfsr_q[31:16];
        b_d   = lfsr_q[15:0];
        sel_d = cnt_q[1:0];
        cnt_d = cnt_q + 1'b1;
        // The result of the previously applied vector is on alu_out now.
        misr_en = (cnt_q != '0);
        if (cnt_q[1:0] == 2'd3) begin
          lfsr_d = lfsr_next(lfsr_q);
        end
        if (cnt_q == LastVec) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        misr_en = 1'b1;
        state_d = StCheck;
      end
      StCheck: begin
        pass_d  = (sig == GOLDEN_SIG);
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (abort_i && (state_q != StIdle)) begin
      state_d = StIdle;
      busy_d  = 1'b0;
      pass_d  = 1'b0;
      done_d  = 1'b0;
      misr_en = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      lfsr_q  <= SEED;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  alu_bist_misr u_misr (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (misr_clr),
    .en_i   (misr_en),
    .data_i (alu_io.alu_out),
    .sig_o  (sig)
  );

  assign alu_io.alu_a  = a_q;
  assign alu_io.alu_b  = b_q;
  assign alu_io.alu_s0 = sel_q[0];
  assign alu_io.alu_s1 = sel_q[1];
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign pass_o        = pass_q;
  assign sig_o         = sig;

endmodule

// File: doc/alu_bist_ctrl.md
ALU_BIST_CTRL -- requirements
Module: alu_bist_ctrl

Interface
REQ-001 Parameter N_PATTERNS, 64, operand pairs generated per run (1..1024); each pair applied with all four ops.
REQ-002 Parameter SEED, 32'hACE1_0001, LFSR load value; nonzero.
REQ-003 Parameter GOLDEN_SIG, 16'h0000, expected final MISR signature.
REQ-004 clk  in  1  single clock, rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 start  in  1  run request, sampled in IDLE only.
REQ-007 abort  in  1  cancel the run in progress.
REQ-008 alu_a  out  16  operand A to ALU under test.
REQ-009 alu_b  out  16  operand B to ALU under test.
REQ-010 alu_s0  out  1  op select bit 0.
REQ-011 alu_s1  out  1  op select bit 1.
REQ-012 alu_out  in  16  ALU result, combinational from alu_a/alu_b/alu_s0/alu_s1.
REQ-013 busy  out  1  run in progress.
REQ-014 done  out  1  one-cycle pulse at run completion.
REQ-015 pass  out  1  final signature equals GOLDEN_SIG; held until the next start.
REQ-016 sig  out  16  current MISR value.

Function
REQ-017 FSM states: IDLE, RUN, DRAIN, CHECK.
REQ-018 IDLE with start=1: LFSR<=SEED, op<=0, vector count<=0, MISR<=16'hFFFF, busy<=1, pass<=0, go to RUN.
REQ-019 RUN: each edge registers alu_a=LFSR[31:16], alu_b=LFSR[15:0], {alu_s1,alu_s0}=op; op increments mod 4.
REQ-020 LFSR advances only on the edge where op wraps 3->0: next = {L[30:0],1'b0} ^ (L[31] ? 32'h0040_0007 : 0).
REQ-021 MISR captures alu_out on the edge after each vector is applied: next = {M[14:0],1'b0} ^ (M[15] ? 16'h1021 : 0) ^ alu_out.
REQ-022 On the edge applying vector 4*N_PATTERNS-1: go to DRAIN. DRAIN captures the last result, then goes to CHECK.
REQ-023 CHECK: pass<=(MISR==GOLDEN_SIG), done<=1 for one cycle, busy<=0, go to IDLE.
REQ-024 Latency: done is high in the cycle 4*N_PATTERNS+2 edges after the edge that sampled start.
REQ-025 alu_a, alu_b and the select outputs hold their last value in IDLE.
REQ-026 start while not IDLE is ignored. Start in the done cycle is accepted, since the FSM is already in IDLE.
REQ-027 abort in RUN/DRAIN/CHECK: next edge enters IDLE with busy=0, pass=0, and done not asserted. abort has priority over the CHECK actions. abort in IDLE has no effect.
REQ-028 Simultaneous start and abort in IDLE: start wins.

Reset
REQ-029 rst=1 immediately forces IDLE with alu_a=0, alu_b=0, alu_s0=0, alu_s1=0, busy=0, done=0, pass=0, sig=16'hFFFF, LFSR=SEED, counters=0, regardless of state.

Structure
REQ-030 Package alu_bist_pkg holds the state encoding, LFSR mask 32'h0040_0007, MISR mask 16'h1021, MISR init 16'hFFFF and default SEED.
REQ-031 Sub-module alu_bist_misr (16-bit MISR with clear/enable) is instantiated once; the FSM, LFSR and counters stay in alu_bist_ctrl.

Verification
REQ-032 Reset: assert rst mid-cycle -> all outputs at reset values before the next edge; sig=16'hFFFF.
REQ-033 N_PATTERNS=1, alu_out tied 16'h0000, GOLDEN_SIG=16'h0E1F, pulse start -> four vectors a=16'hACE1, b=16'h0001 with s1s0=00,01,10,11; sig=16'h0E1F; done 6 edges after start; pass=1.
REQ-034 Same setup with alu_out tied 16'h0001 -> pass=0 and done at the same cycle.
REQ-035 N_PATTERNS=2, behavioural ALU model -> vectors 4..7 carry one LFSR step of SEED; sig matches the bench MISR model; done at edge 10.
REQ-036 start re-pulsed at edges 3 and 5 of a run -> ignored, and timing is unchanged. abort at edge 10 with N_PATTERNS=64 -> busy=0 at edge 11, no done pulse, pass=0.
REQ-037 rst pulsed at edge 20 of a run -> reset values; a fresh start then produces the same sig as an uninterrupted run.
